// File: rtl/dcache_write_responder_pkg.sv
// dcache_write_responder_pkg
//   Shared definitions for the data-side write path: tag field constants,
//   accept/drain FSM state enums, and the write-buffer entry layout.
//   Tag layout (13 bits): {dir, type[3:0], space, id[6:0]}.
package dcache_write_responder_pkg;

  localparam int unsigned TAG_W       = 13;
  localparam int unsigned TAG_DIR_BIT = TAG_W - 1;

  // Buffer entries are sized for the widest supported address/data;
  // narrower instances zero-extend on push and truncate on drain.
  localparam int unsigned ADDR_W_MAX = 64;
  localparam int unsigned DATA_W_MAX = 64;

  localparam logic       TAG_DIR_WRITE   = 1'b1;
  localparam logic       TAG_DIR_READ    = 1'b0;
  localparam logic [3:0] TAG_TYPE_MEMORY = 4'b0001;
  localparam logic       TAG_SPACE_DATA  = 1'b1;
  localparam logic       TAG_SPACE_INSN  = 1'b0;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_ACKED = 2'd1,
    A_WAIT  = 2'd2
  } accept_state_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_REQ  = 2'd1,
    D_WACK = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic [ADDR_W_MAX-1:0] addr;
    logic [DATA_W_MAX-1:0] data;
    logic [TAG_W-1:0]      tag;
  } wbuf_entry_t;

  function automatic logic tag_is_write(input logic [TAG_W-1:0] tag);
    return tag[TAG_DIR_BIT] == TAG_DIR_WRITE;
  endfunction

endpackage

// File: rtl/dcache_wbuf_fifo.sv
// dcache_wbuf_fifo
//   Synchronous write-buffer FIFO of wbuf_entry_t, DEPTH entries (power of 2).
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     push_i, entry_i  enqueue request and entry (ignored when full)
//     pop_i            dequeue request (ignored when empty)
//     head_o           oldest entry
//     occupancy_o      number of valid entries
//     full_o, empty_o  derived from registered occupancy
module dcache_wbuf_fifo
  import dcache_write_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  wbuf_entry_t      entry_i,
  input  logic             pop_i,
  output wbuf_entry_t      head_o,
  output logic [CNT_W-1:0] occupancy_o,
  output logic             full_o,
  output logic             empty_o
);

  wbuf_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o      = (cnt_q == CNT_W'(DEPTH));
  assign empty_o     = (cnt_q == '0);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign occupancy_o = cnt_q;
  assign head_o      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset: occupancy alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/dcache_write_responder.sv
// dcache_write_responder
//   Responder end of the data-side core/cache write protocol. Accepts core
//   writes, acknowledges them with one-cycle reqack/writeack pulses, buffers
//   them in dcache_wbuf_fifo and replays them in order to the memory port.
//   Configuration macro: DCACHE_POSTED_WRITE_EN
//     defined   - posted: writeack one cycle after reqack, up to DEPTH in flight
//     undefined - non-posted: writeack after the memory completes the write
//   Ports:
//     clk, reset                         clock, asynchronous active-low reset
//     reqcyc, req, reqdata, reqtag       core write request (held until reqack)
//     reqack, writeack                   core-side accept / completion pulses
//     mem_reqcyc, mem_req, mem_reqdata,  memory-side drained request
//     mem_reqtag
//     mem_reqack, mem_writeack           memory-side accept / completion
//     occupancy                          valid buffer entries
//     tag_err                            sticky: non-WRITE request observed
module dcache_write_responder
  import dcache_write_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reqcyc,
  input  logic [ADDR_W-1:0]      req,
  input  logic [DATA_W-1:0]      reqdata,
  input  logic [TAG_W-1:0]       reqtag,
  output logic                   reqack,
  output logic                   writeack,
  output logic                   mem_reqcyc,
  output logic [ADDR_W-1:0]      mem_req,
  output logic [DATA_W-1:0]      mem_reqdata,
  output logic [TAG_W-1:0]       mem_reqtag,
  input  logic                   mem_reqack,
  input  logic                   mem_writeack,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   tag_err
);

  accept_state_e     a_state_q, a_state_d;
  drain_state_e      d_state_q, d_state_d;
  logic              reqack_q, reqack_d;
  logic              writeack_q, writeack_d;
  logic              tag_err_q, tag_err_d;
  logic              mem_reqcyc_q, mem_reqcyc_d;
  logic [ADDR_W-1:0] mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_reqdata_q, mem_reqdata_d;
  logic [TAG_W-1:0]  mem_reqtag_q, mem_reqtag_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  wbuf_entry_t fifo_in, fifo_head;

  assign fifo_in.addr = ADDR_W_MAX'(req);
  assign fifo_in.data = DATA_W_MAX'(reqdata);
  assign fifo_in.tag  = reqtag;

  dcache_wbuf_fifo #(.DEPTH(DEPTH)) u_wbuf (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fifo_push),
    .entry_i     (fifo_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .occupancy_o (occupancy),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Accept FSM. A_ACKED deliberately ignores reqcyc: the initiator only
  // drops it after seeing reqack, so it is still high for one extra cycle.
  always_comb begin
    a_state_d  = a_state_q;
    reqack_d   = 1'b0;
    writeack_d = 1'b0;
    tag_err_d  = tag_err_q;
    fifo_push  = 1'b0;
    case (a_state_q)
      A_IDLE: begin
        if (reqcyc) begin
          if (!tag_is_write(reqtag)) begin
            tag_err_d = 1'b1;
          end else if (!fifo_full) begin
            fifo_push = 1'b1;
            reqack_d  = 1'b1;
            a_state_d = A_ACKED;
          end
        end
      end
      A_ACKED: begin
`ifdef DCACHE_POSTED_WRITE_EN
        writeack_d = 1'b1;
        a_state_d  = A_IDLE;
`else
        a_state_d  = A_WAIT;
`endif
      end
`ifndef DCACHE_POSTED_WRITE_EN
      // Only one write is ever buffered here, so any pop completes it.
      A_WAIT: begin
        if (fifo_pop) begin
          writeack_d = 1'b1;
          a_state_d  = A_IDLE;
        end
      end
`endif
      default: a_state_d = A_IDLE;
    endcase
  end

  // Drain FSM. The head is latched into the mem_* registers on issue so the
  // request stays stable regardless of later pushes.
  always_comb begin
    d_state_d     = d_state_q;
    mem_reqcyc_d  = mem_reqcyc_q;
    mem_req_d     = mem_req_q;
    mem_reqdata_d = mem_reqdata_q;
    mem_reqtag_d  = mem_reqtag_q;
    fifo_pop      = 1'b0;
    case (d_state_q)
      D_IDLE: begin
        if (!fifo_empty) begin
          mem_reqcyc_d  = 1'b1;
          mem_req_d     = ADDR_W'(fifo_head.addr);
          mem_reqdata_d = DATA_W'(fifo_head.data);
          mem_reqtag_d  = fifo_head.tag;
          d_state_d     = D_REQ;
        end
      end
      D_REQ: begin
        if (mem_reqack) begin
          mem_reqcyc_d = 1'b0;
          if (mem_writeack) begin
            fifo_pop  = 1'b1;
            d_state_d = D_IDLE;
          end else begin
            d_state_d = D_WACK;
          end
        end
      end
      D_WACK: begin
        if (mem_writeack) begin
          fifo_pop  = 1'b1;
          d_state_d = D_IDLE;
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_state_q     <= A_IDLE;
      d_state_q     <= D_IDLE;
      reqack_q      <= 1'b0;
      writeack_q    <= 1'b0;
      tag_err_q     <= 1'b0;
      mem_reqcyc_q  <= 1'b0;
      mem_req_q     <= '0;
      mem_reqdata_q <= '0;
      mem_reqtag_q  <= '0;
    end else begin
      a_state_q     <= a_state_d;
      d_state_q     <= d_state_d;
      reqack_q      <= reqack_d;
      writeack_q    <= writeack_d;
      tag_err_q     <= tag_err_d;
      mem_reqcyc_q  <= mem_reqcyc_d;
      mem_req_q     <= mem_req_d;
      mem_reqdata_q <= mem_reqdata_d;
      mem_reqtag_q  <= mem_reqtag_d;
    end
  end

  assign reqack      = reqack_q;
  assign writeack    = writeack_q;
  assign tag_err     = tag_err_q;
  assign mem_reqcyc  = mem_reqcyc_q;
  assign mem_req     = mem_req_q;
  assign mem_reqdata = mem_reqdata_q;
  assign mem_reqtag  = mem_reqtag_q;

endmodule

// File: tb/tb_dcache_write_responder.sv
`timescale 1ns/1ps
module tb_dcache_write_responder;
  import dcache_write_responder_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
`ifdef DCACHE_POSTED_WRITE_EN
  localparam int NENT = 3;
`else
  localparam int NENT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reqcyc = 1'b0;
  logic [63:0]   req = '0;
  logic [63:0]   reqdata = '0;
  logic [12:0]   reqtag = '0;
  logic          reqack, writeack, mem_reqcyc, tag_err;
  logic [63:0]   mem_req, mem_reqdata;
  logic [12:0]   mem_reqtag;
  logic          mem_reqack = 1'b0;
  logic          mem_writeack = 1'b0;
  logic [CW-1:0] occupancy;

  logic [12:0] WR_TAG, RD_TAG;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  dcache_write_responder #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .reqcyc       (reqcyc),
    .req          (req),
    .reqdata      (reqdata),
    .reqtag       (reqtag),
    .reqack       (reqack),
    .writeack     (writeack),
    .mem_reqcyc   (mem_reqcyc),
    .mem_req      (mem_req),
    .mem_reqdata  (mem_reqdata),
    .mem_reqtag   (mem_reqtag),
    .mem_reqack   (mem_reqack),
    .mem_writeack (mem_writeack),
    .occupancy    (occupancy),
    .tag_err      (tag_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: buffer contents as a queue, core side as "available
  // to sample" plus pulse predictions, memory side as one outstanding issue.
  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic [12:0] t;
  } ent_t;
  ent_t mq[$];
  bit m_reqack, m_writeack, m_tagerr, m_memcyc, m_issued, m_busy;
  bit avail, acc, pop, prev_acc;
  int sz0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_reqack = 0; m_writeack = 0; m_tagerr = 0;
      m_memcyc = 0; m_issued = 0; m_busy = 0;
    end else begin
      sz0      = mq.size();
      avail    = !m_busy;
      prev_acc = m_reqack;
      acc      = avail && reqcyc && reqtag[12] && (sz0 < DEPTH);
      if (avail && reqcyc && !reqtag[12]) m_tagerr = 1;
      pop = 0;
      if (!m_issued) begin
        if (sz0 > 0) begin m_issued = 1; m_memcyc = 1; end
      end else if (m_memcyc) begin
        if (mem_reqack) begin m_memcyc = 0; pop = mem_writeack; end
      end else begin
        pop = mem_writeack;
      end
      if (pop) begin void'(mq.pop_front()); m_issued = 0; end
      if (acc) mq.push_back('{req, reqdata, reqtag});
      m_reqack = acc;
`ifdef DCACHE_POSTED_WRITE_EN
      m_writeack = prev_acc;
      m_busy     = acc;
`else
      m_writeack = m_busy && pop;
      if (pop) m_busy = 0;
      if (acc) m_busy = 1;
`endif
    end
  end

  always @(negedge clk) begin
    if (mon_en && reset) begin
      chk("cmp_reqack", reqack, m_reqack);
      chk("cmp_writeack", writeack, m_writeack);
      chk("cmp_tag_err", tag_err, m_tagerr);
      chk("cmp_mem_reqcyc", mem_reqcyc, m_memcyc);
      chk("cmp_occupancy", occupancy, mq.size());
      if (m_memcyc && mq.size() > 0) begin
        chk("cmp_mem_req", mem_req, mq[0].a);
        chk("cmp_mem_reqdata", mem_reqdata, mq[0].d);
        chk("cmp_mem_reqtag", mem_reqtag, mq[0].t);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core initiator: holds reqcyc until reqack is seen, then one cycle more.
  task automatic core_write(input logic [63:0] a, input logic [63:0] d,
                            input logic [12:0] t, input int bound);
    bit got;
    got = 0;
    req = a; reqdata = d; reqtag = t; reqcyc = 1;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (reqack) got = 1;
    end
    chk("reqack_timeout", got, 1);
    tick();
    reqcyc = 0;
  endtask

  task automatic mem_serve(input int gap, input bit both);
    int n;
    n = 0;
    while (!mem_reqcyc && n < 40) begin @(negedge clk); n++; end
    chk("mem_reqcyc_timeout", mem_reqcyc, 1);
    tick();
    mem_reqack = 1;
    if (both) mem_writeack = 1;
    tick();
    mem_reqack = 0; mem_writeack = 0;
    if (!both) begin
      repeat (gap) tick();
      mem_writeack = 1;
      tick();
      mem_writeack = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    WR_TAG = {TAG_DIR_WRITE, TAG_TYPE_MEMORY, TAG_SPACE_DATA, 7'h05};
    RD_TAG = {TAG_DIR_READ, TAG_TYPE_MEMORY, TAG_SPACE_INSN, 7'h06};

    // Reset state
    repeat (3) tick();
    chk("rst_reqack", reqack, 0);
    chk("rst_writeack", writeack, 0);
    chk("rst_mem_reqcyc", mem_reqcyc, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_tag_err", tag_err, 0);
    reset = 1;
    mon_en = 1;
    tick();

`ifdef DCACHE_POSTED_WRITE_EN
    // Posted single write
    req = 64'h1000; reqdata = 64'hDEADBEEF; reqtag = WR_TAG; reqcyc = 1;
    @(negedge clk); chk("p1_reqack_early", reqack, 0);
    @(negedge clk); chk("p1_reqack_p1", reqack, 1);
    chk("p1_writeack_p1", writeack, 0);
    @(posedge clk); #1 reqcyc = 0;
    @(negedge clk);
    chk("p1_writeack_p2", writeack, 1);
    chk("p1_mem_reqcyc_p2", mem_reqcyc, 1);
    chk("p1_mem_req", mem_req, 64'h1000);
    chk("p1_mem_reqdata", mem_reqdata, 64'hDEADBEEF);
    chk("p1_single_push", occupancy, 1);
    mem_serve(1, 0);
    chk("p1_occ_drained", occupancy, 0);
    tick();

    // Posted overflow: four accepted, fifth waits for one drain
    for (int i = 0; i < 4; i++)
      core_write(64'h4000 + 64'(i * 8), 64'hA0 + 64'(i), WR_TAG, 10);
    fork
      core_write(64'h4020, 64'hA4, WR_TAG, 40);
      begin
        repeat (4) tick();
        chk("p2_occ_full", occupancy, 4);
        chk("p2_fifth_held", reqack, 0);
        mem_reqack = 1; mem_writeack = 1;
        tick();
        mem_reqack = 0; mem_writeack = 0;
        @(negedge clk);
        chk("p2_no_ack_on_pop_cycle", reqack, 0);
        chk("p2_occ_after_pop", occupancy, 3);
        @(negedge clk);
        chk("p2_fifth_ack", reqack, 1);
      end
    join
    repeat (4) mem_serve(0, 0);
    tick();
    chk("p2_occ_drained", occupancy, 0);
`else
    // Non-posted write: writeack waits for the memory completion
    req = 64'h2000; reqdata = 64'h1234_5678; reqtag = WR_TAG; reqcyc = 1;
    @(negedge clk); chk("n1_reqack_early", reqack, 0);
    @(negedge clk); chk("n1_reqack_p1", reqack, 1);
    @(posedge clk); #1 reqcyc = 0;
    @(negedge clk);
    chk("n1_writeack_withheld", writeack, 0);
    chk("n1_mem_reqcyc", mem_reqcyc, 1);
    chk("n1_mem_req", mem_req, 64'h2000);
    chk("n1_single_push", occupancy, 1);
    tick();
    req = 64'h2008; reqdata = 64'h55AA; reqcyc = 1;
    mem_reqack = 1;
    tick();
    mem_reqack = 0;
    repeat (4) tick();
    mem_writeack = 1;
    @(negedge clk);
    chk("n1_writeack_before_mem", writeack, 0);
    chk("n1_second_not_acked", reqack, 0);
    @(posedge clk); #1 mem_writeack = 0;
    @(negedge clk);
    chk("n1_writeack_after_mem", writeack, 1);
    chk("n1_second_still_waiting", reqack, 0);
    @(negedge clk);
    chk("n1_second_acked", reqack, 1);
    @(posedge clk); #1 reqcyc = 0;
    mem_serve(2, 0);
    tick();
    chk("n1_occ_drained", occupancy, 0);
`endif

    // Read-direction tag: no accept, sticky error
    tick();
    req = 64'h3000; reqtag = RD_TAG; reqcyc = 1;
    repeat (3) begin @(negedge clk); chk("rd_no_reqack", reqack, 0); end
    chk("rd_tag_err", tag_err, 1);
    tick();
    reqcyc = 0;
    repeat (4) tick();
    chk("rd_tag_err_sticky", tag_err, 1);
    chk("rd_no_push", occupancy, 0);

    // Reset while waiting for the memory write completion
    for (int i = 0; i < NENT; i++)
      core_write(64'h5000 + 64'(i * 8), 64'hB0 + 64'(i), WR_TAG, 10);
    mem_reqack = 1;
    tick();
    mem_reqack = 0;
    tick();
    chk("rm_occ_before", occupancy, NENT);
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("rm_mem_reqcyc", mem_reqcyc, 0);
    chk("rm_occupancy", occupancy, 0);
    chk("rm_tag_err_cleared", tag_err, 0);
    chk("rm_writeack", writeack, 0);
    tick(); tick();
    reset = 1;
    repeat (6) begin
      @(negedge clk);
      chk("rm_quiet_writeack", writeack, 0);
      chk("rm_quiet_mem_reqcyc", mem_reqcyc, 0);
    end

    // Reset while the memory request is still raised
    tick();
    core_write(64'h6000, 64'hC0, WR_TAG, 10);
    @(negedge clk);
    chk("rq_mem_reqcyc_up", mem_reqcyc, 1);
    #2 reset = 0;
    #1;
    chk("rq_mem_reqcyc_async_drop", mem_reqcyc, 0);
    chk("rq_occupancy", occupancy, 0);
    tick(); tick();
    reset = 1;
    tick();

    // Fresh write after reset, drained with reqack+writeack together
    core_write(64'h7000, 64'hD0, WR_TAG, 10);
    mem_serve(0, 1);
    repeat (3) tick();
    chk("fin_occ", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_write_responder.md
# dcache_write_responder

Responder end of the data-side core/cache write protocol. Accepts write requests from the pipeline's write-back stage (`reqcyc`/`req`/`reqdata`/`reqtag`), answers with single-cycle `reqack` and `writeack` pulses, and holds accepted writes in a small FIFO. A drain engine replays the buffered writes, in order, to the memory-side port using the same handshake. It sits between the core's write-back stage and the memory/arbiter.

## Interface
- `DEPTH`, 4, write-buffer entries; power of two, ≥2.
- `ADDR_W`, 64, address width.
- `DATA_W`, 64, data width.
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `reqcyc`  in  1  core request valid; held until `reqack` is seen.
- `req`  in  ADDR_W  write address.
- `reqdata`  in  DATA_W  write data.
- `reqtag`  in  13  {dir, type[3:0], space, id[6:0]}.
- `reqack`  out  1  one-cycle accept pulse.
- `writeack`  out  1  one-cycle write-complete pulse.
- `mem_reqcyc`  out  1  memory-side request valid.
- `mem_req`  out  ADDR_W  drained address.
- `mem_reqdata`  out  DATA_W  drained data.
- `mem_reqtag`  out  13  drained tag, copied from the entry.
- `mem_reqack`  in  1  memory accept.
- `mem_writeack`  in  1  memory write complete.
- `occupancy`  out  $clog2(DEPTH)+1  valid entries.
- `tag_err`  out  1  sticky; set when a request without WRITE direction is seen.

## Operation
- Accept FSM has states A_IDLE, A_ACKED and A_WAIT.
  - A_IDLE: if `reqcyc`=1, tag dir=WRITE and FIFO not full, push {req, reqdata, reqtag}, register `reqack`=1, go to A_ACKED.
  - A_IDLE with `reqcyc`=1 and a non-WRITE tag: no push and no ack; set `tag_err`.
- A_ACKED: ignore `reqcyc`, because the initiator drops it one cycle late and a late request must not be double-captured.
  - Posted mode: pulse `writeack`, return to A_IDLE.
  - Non-posted mode: go to A_WAIT.
- A_WAIT (non-posted only): remain until the drain engine completes that entry, then pulse `writeack` and return to A_IDLE.
- Drain FSM has states D_IDLE, D_REQ and D_WACK.
  - D_IDLE: if the FIFO is not empty, present the head on the mem_* outputs, set `mem_reqcyc`=1, go to D_REQ.
  - D_REQ: on `mem_reqack`, clear `mem_reqcyc` next cycle and go to D_WACK.
  - D_WACK: on `mem_writeack`, pop the head and go to D_IDLE.
- `mem_req`, `mem_reqdata` and `mem_reqtag` stay stable while `mem_reqcyc`=1.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full and empty are decided by `occupancy`.
- Push and pop in the same cycle: `occupancy` is unchanged and both are honoured.
- Full is judged on registered `occupancy`; a pop in the same cycle does not unblock that cycle's push.
- `mem_reqack` and `mem_writeack` in the same cycle while in D_REQ: treat as both, pop and go to D_IDLE.

## Timing
- Reset values:
  - all outputs 0, `tag_err` 0;
  - FIFO empty, pointers 0;
  - FSMs in A_IDLE/D_IDLE.
- Reset asserted mid-transaction: buffered writes are discarded, `mem_reqcyc` drops immediately (asynchronous), and no `writeack` is issued.
- `reqack` latency: 1 cycle after `reqcyc` is sampled high with space available.
- Posted `writeack`: 1 cycle after `reqack`.
- Non-posted `writeack`: 1 cycle after `mem_writeack` for that entry.
- Minimum core-side accept interval: 3 cycles (accept, ACKED, IDLE re-sample).
- Drain: `mem_reqcyc` rises 1 cycle after a push into an empty FIFO.
- Full FIFO: `reqcyc` is held with no `reqack`. Accept occurs the cycle after `occupancy` drops below DEPTH.

## Configuration
- `DCACHE_POSTED_WRITE_EN` defined: posted mode; `writeack` follows `reqack`, and up to DEPTH writes are in flight.
- `DCACHE_POSTED_WRITE_EN` undefined: non-posted mode; `writeack` waits for memory completion.
  - At most one core write is outstanding; the FIFO never exceeds 1 entry.
  - A_WAIT is compiled in.

## Structure
- The shared cache package holds:
  - tag field constants: WRITE=1, READ=0, MEMORY=4'b0001, DATA=1, INSN=0, and the tag width 13;
  - the accept-state and drain-state enums;
  - the buffer-entry struct {addr, data, tag}.
- Sub-module `dcache_wbuf_fifo`: parameterised synchronous FIFO (push, pop, head, occupancy, full, empty).

## Test plan
- Posted, single write: `reqcyc` with req=0x1000, reqdata=0xDEADBEEF, WRITE tag.
  - `reqack` at +1, `writeack` at +2.
  - `mem_reqcyc` at +2 with the same address and data.
  - `mem_writeack` → `occupancy` returns to 0.
- Posted, back-to-back overflow: five writes with `mem_reqack` held low.
  - Four `reqack` pulses; the fifth `reqcyc` waits.
  - A single `mem_reqack` plus `mem_writeack` drain is followed by the fifth ack 1 cycle later.
- Late-drop check: `reqcyc` held high one cycle past `reqack` → exactly one push and one `reqack`.
- Non-posted (macro undefined): write to 0x2000.
  - `writeack` is withheld until `mem_writeack`, arriving 5 cycles later, then asserts at +1.
  - A second `reqcyc` is not acked before that.
- Read tag: `reqtag` dir=0 → no `reqack`, `tag_err`=1 and sticky until reset.
- Reset mid-drain: `reset`=0 while in D_WACK with 3 entries.
  - `mem_reqcyc`=0 and `occupancy`=0 immediately.
  - After release, no `writeack` or `mem_reqcyc` until a new request.
